ex_ls: RTL

//  EXU->LSU pipeline stage register; the downstream counterpart of the ID->EX stage.

---
 rtl/ex_ls_if.sv | 42 ++++
 rtl/ex_ls.sv | 110 +++++++++++
 2 files changed

// File: rtl/ex_ls_if.sv
// EXU->LSU stage bus: e_* payload/valid in from EXU, m_* payload/valid out to LSU, with ready in each direction.
interface ex_ls_if #(
  parameter int XLEN   = 32,
  parameter int RS_W   = 5,
  parameter int MASK_W = 4
);
  logic [XLEN-1:0]   e_result_i;
  logic [XLEN-1:0]   e_src2_i;
  logic              e_wenReg_i;
  logic [RS_W-1:0]   e_rd_i;
  logic              e_wenMem_i;
  logic              e_renMem_i;
  logic [MASK_W-1:0] e_mask_i;
  logic              e_is_load_signed_i;
  logic              e_valid_i;
  logic              M_ready_o;

  logic [XLEN-1:0]   m_result_o;
  logic [XLEN-1:0]   m_src2_o;
  logic              m_wenReg_o;
  logic [RS_W-1:0]   m_rd_o;
  logic              m_wenMem_o;
  logic              m_renMem_o;
  logic [MASK_W-1:0] m_mask_o;
  logic              m_is_load_signed_o;
  logic              M_valid_o;
  logic              m_ready_i;

  modport slave (
    input  e_result_i, e_src2_i, e_wenReg_i, e_rd_i, e_wenMem_i, e_renMem_i,
           e_mask_i, e_is_load_signed_i, e_valid_i, m_ready_i,
    output m_result_o, m_src2_o, m_wenReg_o, m_rd_o, m_wenMem_o, m_renMem_o,
           m_mask_o, m_is_load_signed_o, M_valid_o, M_ready_o
  );

  modport master (
    output e_result_i, e_src2_i, e_wenReg_i, e_rd_i, e_wenMem_i, e_renMem_i,
           e_mask_i, e_is_load_signed_i, e_valid_i, m_ready_i,
    input  m_result_o, m_src2_o, m_wenReg_o, m_rd_o, m_wenMem_o, m_renMem_o,
           m_mask_o, m_is_load_signed_o, M_valid_o, M_ready_o
  );
endinterface

// File: rtl/ex_ls.sv
// EXU->LSU pipeline register, 1-cycle latency. YSYX_23060251_PIPE_SKID_EN selects a 2-entry skid
// (registered ready); otherwise a single register with ready = ~main_v | m_ready_i.
module ex_ls #(
  parameter int XLEN   = 32,
  parameter int RS_W   = 5,
  parameter int MASK_W = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  ex_ls_if.slave bus
);
  localparam int PW = 2*XLEN + RS_W + MASK_W + 4;

  logic [PW-1:0] w_in;
  logic [PW-1:0] r_main;
  logic          w_main_v;
  logic          w_ready;
  logic          w_in_fire;
  logic          w_out_fire;

  assign w_in = {bus.e_result_i, bus.e_src2_i, bus.e_wenReg_i, bus.e_rd_i,
                 bus.e_wenMem_i, bus.e_renMem_i, bus.e_mask_i, bus.e_is_load_signed_i};

  assign w_in_fire  = bus.e_valid_i & w_ready;
  assign w_out_fire = w_main_v & bus.m_ready_i;

  assign {bus.m_result_o, bus.m_src2_o, bus.m_wenReg_o, bus.m_rd_o,
          bus.m_wenMem_o, bus.m_renMem_o, bus.m_mask_o, bus.m_is_load_signed_o} = r_main;
  assign bus.M_valid_o = w_main_v;
  assign bus.M_ready_o = w_ready;

`ifdef YSYX_23060251_PIPE_SKID_EN
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_BUSY = 2'd1, S_FULL = 2'd2} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_skid;
  logic          w_ld_main;
  logic          w_ld_skid;
  logic          w_main_from_skid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ld_main        = 1'b0;
    w_ld_skid        = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_ld_main   = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_main = 1'b1;
        end else if (w_in_fire) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = S_FULL;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // ready is low here, so only the drain path exists
        if (w_out_fire) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = S_BUSY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main)             r_main <= w_in;
      else if (w_main_from_skid) r_main <= r_skid;
      if (w_ld_skid)             r_skid <= w_in;
    end
  end

  assign w_main_v = (r_state != S_EMPTY);
  assign w_ready  = ~rst_i & (r_state != S_FULL);
`else
  logic r_main_v;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_v <= 1'b0;
      r_main   <= '0;
    end else begin
      if (w_in_fire)       r_main_v <= 1'b1;
      else if (w_out_fire) r_main_v <= 1'b0;
      if (w_in_fire)       r_main   <= w_in;
    end
  end

  assign w_main_v = r_main_v;
  assign w_ready  = ~rst_i & (~r_main_v | bus.m_ready_i);
`endif
endmodule
